// File: rtl/mem_subsys_if.sv
// Bundled load-port, fetch, data-bus and status signals of mem_subsys.
// master = core/loader side, slave = memory subsystem side.
interface mem_subsys_if #(
    parameter int unsigned p_WORD_LEN      = 16,
    parameter int unsigned p_CORE_ADDR_LEN = 16,
    parameter int unsigned p_CNT_LEN       = 8
) ();
    logic                       i_ld_valid;
    logic                       o_ld_ready;
    logic [p_WORD_LEN-1:0]      i_ld_data;
    logic                       i_ld_last;
    logic                       i_reload;
    logic                       o_core_rst;
    logic                       o_running;
    logic [p_CORE_ADDR_LEN-1:0] i_pc;
    logic [p_WORD_LEN-1:0]      o_inst;
    logic [p_CORE_ADDR_LEN-1:0] i_mem_addr;
    logic [p_WORD_LEN-1:0]      i_mem_wr_data;
    logic                       i_mem_wr_en;
    logic [p_WORD_LEN-1:0]      o_mem_rd_data;
    logic                       o_oob_err;
    logic [p_CNT_LEN-1:0]       o_oob_cnt;

    modport master (
        output i_ld_valid, i_ld_data, i_ld_last, i_reload,
               i_pc, i_mem_addr, i_mem_wr_data, i_mem_wr_en,
        input  o_ld_ready, o_core_rst, o_running, o_inst,
               o_mem_rd_data, o_oob_err, o_oob_cnt
    );

    modport slave (
        input  i_ld_valid, i_ld_data, i_ld_last, i_reload,
               i_pc, i_mem_addr, i_mem_wr_data, i_mem_wr_en,
        output o_ld_ready, o_core_rst, o_running, o_inst,
               o_mem_rd_data, o_oob_err, o_oob_cnt
    );
endinterface

// File: rtl/mem_subsys.sv
// RISC16 memory subsystem: I-mem/D-mem, boot sequencer (clear -> load -> run), OOB write monitor.
// Define MEMSYS_CLEAR_EN to build the post-reset D-mem zero sweep.
module mem_subsys #(
    parameter int unsigned p_WORD_LEN      = 16,
    parameter int unsigned p_INST_ADDR_LEN = 10,
    parameter int unsigned p_DATA_ADDR_LEN = 10,
    parameter int unsigned p_CORE_ADDR_LEN = 16,
    parameter int unsigned p_CNT_LEN       = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    mem_subsys_if.slave bus
);
    localparam int unsigned IMEM_DEPTH = 2 ** p_INST_ADDR_LEN;
    localparam int unsigned DMEM_DEPTH = 2 ** p_DATA_ADDR_LEN;

    typedef enum logic [1:0] {S_CLEAR, S_LOAD, S_RUN} state_e;

`ifdef MEMSYS_CLEAR_EN
    localparam state_e RESET_STATE = S_CLEAR;
`else
    localparam state_e RESET_STATE = S_LOAD;
`endif

    state_e                     state_q, state_d;
    logic [p_INST_ADDR_LEN-1:0] ld_ptr_q, ld_ptr_d;
    logic                       ld_ready_q, ld_ready_d;
    logic                       running_q, running_d;
    logic                       core_rst_q, core_rst_d;
    logic                       oob_err_q, oob_err_d;
    logic [p_CNT_LEN-1:0]       oob_cnt_q, oob_cnt_d;
`ifdef MEMSYS_CLEAR_EN
    logic [p_DATA_ADDR_LEN-1:0] clr_ptr_q, clr_ptr_d;
`endif

    logic [p_WORD_LEN-1:0] imem_q [IMEM_DEPTH];
    logic [p_WORD_LEN-1:0] dmem_q [DMEM_DEPTH];

    logic                       imem_we;
    logic                       dmem_we;
    logic [p_DATA_ADDR_LEN-1:0] dmem_waddr;
    logic [p_WORD_LEN-1:0]      dmem_wdata;
    logic                       ld_hs;
    logic                       pc_in_range;
    logic                       addr_in_range;

    // Full-width range checks: any set bit above the memory index is out of range.
    assign pc_in_range   = (bus.i_pc >> p_INST_ADDR_LEN) == '0;
    assign addr_in_range = (bus.i_mem_addr >> p_DATA_ADDR_LEN) == '0;
    assign ld_hs         = bus.i_ld_valid & ld_ready_q;

    // Sequencer state and status registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= RESET_STATE;
            ld_ptr_q   <= '0;
            ld_ready_q <= 1'b0;
            running_q  <= 1'b0;
            core_rst_q <= 1'b1;
            oob_err_q  <= 1'b0;
            oob_cnt_q  <= '0;
`ifdef MEMSYS_CLEAR_EN
            clr_ptr_q  <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ld_ptr_q   <= ld_ptr_d;
            ld_ready_q <= ld_ready_d;
            running_q  <= running_d;
            core_rst_q <= core_rst_d;
            oob_err_q  <= oob_err_d;
            oob_cnt_q  <= oob_cnt_d;
`ifdef MEMSYS_CLEAR_EN
            clr_ptr_q  <= clr_ptr_d;
`endif
        end
    end

    // Next-state, memory write steering and OOB accounting.
    always_comb begin
        state_d    = state_q;
        ld_ptr_d   = ld_ptr_q;
        oob_err_d  = oob_err_q;
        oob_cnt_d  = oob_cnt_q;
        imem_we    = 1'b0;
        dmem_we    = 1'b0;
        dmem_waddr = bus.i_mem_addr[p_DATA_ADDR_LEN-1:0];
        dmem_wdata = bus.i_mem_wr_data;
`ifdef MEMSYS_CLEAR_EN
        clr_ptr_d  = clr_ptr_q;
`endif
        unique case (state_q)
`ifdef MEMSYS_CLEAR_EN
            S_CLEAR: begin
                dmem_we    = 1'b1;
                dmem_waddr = clr_ptr_q;
                dmem_wdata = '0;
                clr_ptr_d  = clr_ptr_q + p_DATA_ADDR_LEN'(1);
                if (clr_ptr_q == '1) state_d = S_LOAD;
            end
`endif
            S_LOAD: begin
                if (ld_hs) begin
                    imem_we  = 1'b1;
                    ld_ptr_d = ld_ptr_q + p_INST_ADDR_LEN'(1);
                    if (bus.i_ld_last || (ld_ptr_q == '1)) state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (bus.i_mem_wr_en) begin
                    if (addr_in_range) begin
                        dmem_we = 1'b1;
                    end else begin
                        oob_err_d = 1'b1;
                        if (oob_cnt_q != '1) oob_cnt_d = oob_cnt_q + p_CNT_LEN'(1);
                    end
                end
                if (bus.i_reload) begin
                    state_d   = S_LOAD;
                    ld_ptr_d  = '0;
                    oob_err_d = 1'b0;
                    oob_cnt_d = '0;
                end
            end
            default: state_d = S_LOAD;
        endcase
        ld_ready_d = (state_d == S_LOAD);
        running_d  = (state_d == S_RUN);
        core_rst_d = (state_d != S_RUN);
    end

    // Memories carry no reset; writes are suppressed while reset is held so contents survive it.
    always_ff @(posedge i_clk) begin
        if (imem_we) imem_q[ld_ptr_q] <= bus.i_ld_data;
    end

    always_ff @(posedge i_clk) begin
        if (dmem_we && i_rst_n) dmem_q[dmem_waddr] <= dmem_wdata;
    end

    assign bus.o_inst        = pc_in_range ? imem_q[bus.i_pc[p_INST_ADDR_LEN-1:0]] : '0;
    assign bus.o_mem_rd_data = addr_in_range ? dmem_q[bus.i_mem_addr[p_DATA_ADDR_LEN-1:0]] : '0;
    assign bus.o_ld_ready    = ld_ready_q;
    assign bus.o_core_rst    = core_rst_q;
    assign bus.o_running     = running_q;
    assign bus.o_oob_err     = oob_err_q;
    assign bus.o_oob_cnt     = oob_cnt_q;
endmodule

// File: tb/tb_mem_subsys.sv
// Directed bench for mem_subsys with a behavioural boot/memory model checked every cycle.
module tb_mem_subsys;
    localparam int unsigned W   = 16;
    localparam int unsigned IA  = 2;
    localparam int unsigned DA  = 4;
    localparam int unsigned CA  = 16;
    localparam int unsigned CN  = 8;
    localparam int IDEPTH = 4;
    localparam int DDEPTH = 16;
`ifdef MEMSYS_CLEAR_EN
    localparam int CLR_CYC = 16;
    localparam int EXP_RDY = 16;
`else
    localparam int CLR_CYC = 0;
    localparam int EXP_RDY = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    bit   chk_on = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    mem_subsys_if #(.p_WORD_LEN(W), .p_CORE_ADDR_LEN(CA), .p_CNT_LEN(CN)) bus ();

    mem_subsys #(
        .p_WORD_LEN(W), .p_INST_ADDR_LEN(IA), .p_DATA_ADDR_LEN(DA),
        .p_CORE_ADDR_LEN(CA), .p_CNT_LEN(CN)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    // Behavioural model of the boot sequencer and memories.
    logic [15:0] m_imem [IDEPTH];
    logic [15:0] m_dmem [DDEPTH];
    bit          m_iknown [IDEPTH];
    bit          m_dknown [DDEPTH];
    int          m_clear_left;
    bit          m_ready;
    bit          m_run;
    int          m_ptr;
    bit          m_err;
    int          m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_clear_left = CLR_CYC;
            m_ready = 0; m_run = 0; m_ptr = 0; m_err = 0; m_cnt = 0;
        end else if (m_clear_left > 0) begin
            m_dmem[DDEPTH - m_clear_left]   = 16'h0;
            m_dknown[DDEPTH - m_clear_left] = 1;
            m_clear_left--;
            m_ready = (m_clear_left == 0);
        end else if (!m_run) begin
            if (m_ready && bus.i_ld_valid) begin
                m_imem[m_ptr]   = bus.i_ld_data;
                m_iknown[m_ptr] = 1;
                if (bus.i_ld_last || m_ptr == IDEPTH - 1) m_run = 1;
                m_ptr++;
            end
            m_ready = !m_run;
        end else begin
            if (bus.i_mem_wr_en) begin
                if (int'(bus.i_mem_addr) < DDEPTH) begin
                    m_dmem[int'(bus.i_mem_addr)]   = bus.i_mem_wr_data;
                    m_dknown[int'(bus.i_mem_addr)] = 1;
                end else begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            if (bus.i_reload) begin
                m_run = 0; m_ptr = 0; m_err = 0; m_cnt = 0; m_ready = 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            int pc, ad;
            chk("ld_ready", 32'(bus.o_ld_ready), 32'(m_ready));
            chk("core_rst", 32'(bus.o_core_rst), 32'(!m_run));
            chk("running",  32'(bus.o_running),  32'(m_run));
            chk("oob_err",  32'(bus.o_oob_err),  32'(m_err));
            chk("oob_cnt",  32'(bus.o_oob_cnt),  32'(m_cnt));
            pc = int'(bus.i_pc);
            ad = int'(bus.i_mem_addr);
            if (pc >= IDEPTH)      chk("inst", 32'(bus.o_inst), 32'h0);
            else if (m_iknown[pc]) chk("inst", 32'(bus.o_inst), 32'(m_imem[pc]));
            if (ad >= DDEPTH)      chk("rd_data", 32'(bus.o_mem_rd_data), 32'h0);
            else if (m_dknown[ad]) chk("rd_data", 32'(bus.o_mem_rd_data), 32'(m_dmem[ad]));
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        while (!bus.o_ld_ready && n < 100) begin
            tick();
            n++;
        end
        chk(nm, 32'(n), 32'(EXP_RDY));
    endtask

    task automatic load_word(input logic [15:0] d, input bit last);
        bus.i_ld_valid = 1; bus.i_ld_data = d; bus.i_ld_last = last;
        tick();
        bus.i_ld_valid = 0; bus.i_ld_last = 0;
    endtask

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        bus.i_mem_addr = a; bus.i_mem_wr_data = d; bus.i_mem_wr_en = 1;
        tick();
        bus.i_mem_wr_en = 0;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] exp);
        bus.i_pc = pc; #1;
        chk("lit_inst", 32'(bus.o_inst), 32'(exp));
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        bus.i_mem_addr = a; #1;
        chk("lit_rd", 32'(bus.o_mem_rd_data), 32'(exp));
    endtask

    task automatic pulse_reload();
        bus.i_reload = 1;
        tick();
        bus.i_reload = 0;
    endtask

    initial begin
        bus.i_ld_valid = 0; bus.i_ld_data = '0; bus.i_ld_last = 0; bus.i_reload = 0;
        bus.i_pc = '0; bus.i_mem_addr = '0; bus.i_mem_wr_data = '0; bus.i_mem_wr_en = 0;
        rst_n = 1;
        #2 rst_n = 0;
        chk_on = 1;
        #1;
        chk("rst_ready",   32'(bus.o_ld_ready), 32'h0);
        chk("rst_core",    32'(bus.o_core_rst), 32'h1);
        chk("rst_running", 32'(bus.o_running),  32'h0);
        chk("rst_cnt",     32'(bus.o_oob_cnt),  32'h0);
        tick(); tick();
        rst_n = 1;
        wait_ready("ready_delay");
`ifdef MEMSYS_CLEAR_EN
        for (int a = 0; a < DDEPTH; a++) rd(16'(a), 16'h0000);
`endif
        // Load with gaps; core reset drops on the edge taking the last word.
        load_word(16'h1111, 0);
        tick(); tick();
        load_word(16'h2222, 0);
        chk("pre_last_core_rst", 32'(bus.o_core_rst), 32'h1);
        load_word(16'h3333, 1);
        chk("last_core_rst", 32'(bus.o_core_rst), 32'h0);
        chk("last_running",  32'(bus.o_running),  32'h1);
        fetch(16'h0000, 16'h1111);
        fetch(16'h0001, 16'h2222);
        fetch(16'h0002, 16'h3333);
        fetch(16'h0004, 16'h0000);
        fetch(16'h8000, 16'h0000);
        // Data writes, boundary in-range and OOB.
        cpu_write(16'h0003, 16'h1234);
        cpu_write(16'h000F, 16'hCAFE);
        rd(16'h0003, 16'h1234);
        rd(16'h000F, 16'hCAFE);
        cpu_write(16'h0010, 16'hBEEF);
        chk("oob_err_1", 32'(bus.o_oob_err), 32'h1);
        chk("oob_cnt_1", 32'(bus.o_oob_cnt), 32'h1);
        rd(16'h0000, 16'h0000 | (m_dknown[0] ? m_dmem[0] : bus.o_mem_rd_data));
        cpu_write(16'h0400, 16'hBEEF);
        chk("oob_cnt_2", 32'(bus.o_oob_cnt), 32'h2);
        rd(16'h0400, 16'h0000);
        rd(16'h8003, 16'h0000);
        bus.i_mem_addr = 16'h0400; bus.i_mem_wr_data = 16'hBEEF; bus.i_mem_wr_en = 1;
        repeat (300) tick();
        bus.i_mem_wr_en = 0;
        chk("oob_sat", 32'(bus.o_oob_cnt), 32'd255);
        // Reload mid-run; core writes during load are ignored.
        pulse_reload();
        chk("rl_core_rst", 32'(bus.o_core_rst), 32'h1);
        chk("rl_cnt",      32'(bus.o_oob_cnt),  32'h0);
        chk("rl_ready",    32'(bus.o_ld_ready), 32'h1);
        cpu_write(16'h0003, 16'hDEAD);
        rd(16'h0003, 16'h1234);
        load_word(16'hAAAA, 1);
        fetch(16'h0000, 16'hAAAA);
        fetch(16'h0001, 16'h2222);
        rd(16'h000F, 16'hCAFE);
        // Full-depth load; reload while loading is ignored.
        pulse_reload();
        load_word(16'h0A01, 0);
        load_word(16'h0A02, 0);
        pulse_reload();
        load_word(16'h0A03, 0);
        chk("full_not_yet", 32'(bus.o_running), 32'h0);
        load_word(16'h0A04, 0);
        chk("full_running", 32'(bus.o_running), 32'h1);
        fetch(16'h0000, 16'h0A01);
        fetch(16'h0002, 16'h0A03);
        fetch(16'h0003, 16'h0A04);
        fetch(16'h0004, 16'h0000);
        // Reset in the middle of a load.
        pulse_reload();
        load_word(16'h5501, 0);
        load_word(16'h5502, 0);
        rst_n = 0; #1;
        chk("mid_rst_ready", 32'(bus.o_ld_ready), 32'h0);
        chk("mid_rst_core",  32'(bus.o_core_rst), 32'h1);
        @(posedge clk); #1; tick();
        rst_n = 1;
        wait_ready("ready_delay_2");
        load_word(16'h6601, 0);
        load_word(16'h6602, 0);
        load_word(16'h6603, 1);
        chk("restart_running", 32'(bus.o_running), 32'h1);
        fetch(16'h0000, 16'h6601);
        fetch(16'h0002, 16'h6603);
        fetch(16'h0003, 16'h0A04);
        tick(); tick();
        chk_on = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
